// File: rtl/seven_seg_pkg.sv
// Shared 7-segment definitions: scanner states, blank pattern and glyphs.
// Patterns are {g,f,e,d,c,b,a}, active-high.
package seven_seg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [6:0] SEG_d = 7'b1011110;
    localparam logic [6:0] SEG_r = 7'b1010000;
    localparam logic [6:0] SEG_o = 7'b1011100;
    localparam logic [6:0] SEG_P = 7'b1110011;
    localparam logic [6:0] SEG_H = 7'b1110110;
    localparam logic [6:0] SEG_t = 7'b1111000;
    localparam logic [6:0] SEG_C = 7'b0111001;
    localparam logic [6:0] SEG_L = 7'b0111000;

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Slot counter and digit index for the scanner. Exposes next-cycle index and
// frame-end so the top can register its outputs in step with the timer.
module seven_seg_slot_timer #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       run,
    output logic [1:0] idx_nxt,
    output logic       blank_end,
    output logic       slot_end,
    output logic       frame_end,
    output logic       frame_end_nxt
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST      = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx;

    assign blank_end = (cnt == BLANK_END);
    assign slot_end  = (cnt == LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    always_comb begin
        cnt_nxt = cnt;
        idx_nxt = idx;
        if (start) begin
            cnt_nxt = '0;
            idx_nxt = 2'd0;
        end else if (run) begin
            if (slot_end) begin
                cnt_nxt = '0;
                idx_nxt = idx + 2'd1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    assign frame_end_nxt = (cnt_nxt == LAST) && (idx_nxt == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else begin
            cnt <= cnt_nxt;
            idx <= idx_nxt;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit multiplexed 7-seg scanner with per-slot blanking and
// frame-aligned double buffering of the pattern set and drop flag.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYC      = 16,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    input  logic [6:0] seg3,
    input  logic [6:0] seg4,
    input  logic       drop_in,
    output logic [6:0] seg_out,
    output logic [3:0] dig_en,
    output logic       drop_led,
    output logic       frame_done
);

    localparam bit         INV     = (SEG_ACTIVE_LOW != 0);
    localparam logic [6:0] PIN_OFF = INV ? ~SEG_OFF : SEG_OFF;

    state_t           state, state_nxt;
    logic [3:0][6:0]  in_set, disp, shadow;
    logic             disp_drop, shadow_drop, pending;
    logic [1:0]       idx_nxt;
    logic             blank_end, slot_end, frame_end, frame_end_nxt;
    logic             boundary, show_nxt;
    logic [6:0]       pat;

    assign in_set   = {seg4, seg3, seg2, seg1};
    assign boundary = (state == SHOW) && frame_end;

    seven_seg_slot_timer #(
        .CLK_DIV  (CLK_DIV),
        .BLANK_CYC(BLANK_CYC)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        ((state == IDLE) && load),
        .run          (state != IDLE),
        .idx_nxt      (idx_nxt),
        .blank_end    (blank_end),
        .slot_end     (slot_end),
        .frame_end    (frame_end),
        .frame_end_nxt(frame_end_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load)      state_nxt = BLANK;
            BLANK:   if (blank_end) state_nxt = SHOW;
            SHOW:    if (slot_end)  state_nxt = BLANK;
            default:                state_nxt = IDLE;
        endcase
    end

    // A load at a frame boundary (or from idle) goes straight to the display
    // set; any other load parks in the shadow until the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            disp        <= '0;
            disp_drop   <= 1'b0;
            shadow      <= '0;
            shadow_drop <= 1'b0;
            pending     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load && (state == IDLE || boundary)) begin
                disp      <= in_set;
                disp_drop <= drop_in;
                pending   <= 1'b0;
            end else if (load) begin
                shadow      <= in_set;
                shadow_drop <= drop_in;
                pending     <= 1'b1;
            end else if (boundary && pending) begin
                disp      <= shadow;
                disp_drop <= shadow_drop;
                pending   <= 1'b0;
            end
        end
    end

    // Outputs are registered from next-cycle state so they align with it;
    // the display set only changes on edges that lead into BLANK.
    assign show_nxt = (state_nxt == SHOW);
    assign pat      = show_nxt ? disp[idx_nxt] : SEG_OFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_out    <= PIN_OFF;
            dig_en     <= 4'b0000;
            frame_done <= 1'b0;
        end else begin
            seg_out    <= INV ? ~pat : pat;
            dig_en     <= show_nxt ? (4'b0001 << idx_nxt) : 4'b0000;
            frame_done <= show_nxt && frame_end_nxt;
        end
    end

    assign drop_led = disp_drop;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench: CLK_DIV=8, BLANK_CYC=2; an active-high and an active-low
// instance share stimulus so pin polarity is checked on every cycle.
module tb_seven_seg_scanner;

    localparam logic [3:0][6:0] DROP = {7'b1110011, 7'b1011100, 7'b1010000, 7'b1011110};
    localparam logic [3:0][6:0] COLD = {7'b1011110, 7'b0111000, 7'b1011100, 7'b0111001};
    localparam logic [3:0][6:0] HOT  = {7'b0000000, 7'b1111000, 7'b1011100, 7'b1110110};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [6:0] seg1 = '0, seg2 = '0, seg3 = '0, seg4 = '0;
    logic       drop_in = 1'b0;
    logic [6:0] seg_out, seg_out_n, seg_out_x;
    logic [3:0] dig_en, dig_en_x;
    logic       drop_led, frame_done, drop_led_x, frame_done_x;

    int errors = 0;
    int checks = 0;
    int ph = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.CLK_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .load(load),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .drop_in(drop_in),
        .seg_out(seg_out), .dig_en(dig_en), .drop_led(drop_led), .frame_done(frame_done)
    );

    seven_seg_scanner #(.CLK_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1)) dut_n (
        .clk(clk), .rst_n(rst_n), .load(load),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .drop_in(drop_in),
        .seg_out(seg_out_n), .dig_en(dig_en_x), .drop_led(drop_led_x), .frame_done(frame_done_x)
    );

    // {dig_en, seg_out, seg_out of the active-low copy, drop_led, frame_done}
    function automatic logic [19:0] obs();
        return {dig_en, seg_out, seg_out_n, drop_led, frame_done};
    endfunction

    // Expected outputs at frame position p (0 = first blank clock of digit 0).
    function automatic logic [19:0] exp_vec(input int p, input logic [3:0][6:0] s,
                                            input logic d, input logic idle);
        logic [3:0] dg;
        logic [6:0] sg;
        logic       fd;
        int         di;
        di = p / 8;
        dg = 4'b0000;
        sg = 7'b0000000;
        fd = 1'b0;
        if (!idle && (p % 8) >= 2) begin
            dg = 4'b0001 << di;
            sg = s[di];
        end
        if (!idle && p == 31) fd = 1'b1;
        return {dg, sg, ~sg, d, fd};
    endfunction

    task automatic load_set(input logic [3:0][6:0] s, input logic d);
        seg1 = s[0]; seg2 = s[1]; seg3 = s[2]; seg4 = s[3];
        drop_in = d;
        load = 1'b1;
    endtask

    task automatic adv();
        @(negedge clk);
        load = 1'b0;
        ph = (ph + 1) % 32;
    endtask

    task automatic test_reset();
        logic [19:0] e;
        e = exp_vec(0, DROP, 1'b0, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", i, obs(), e);
            end
        end
    endtask

    task automatic test_drop();
        logic [19:0] e;
        load_set(DROP, 1'b1);
        @(negedge clk);
        load = 1'b0;
        ph = 0;
        for (int i = 0; i < 32; i++) begin
            e = exp_vec(ph, DROP, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL drop_frame ph=%0d got=%h exp=%h", ph, obs(), e);
            end
            if (i < 31) adv();
        end
    endtask

    task automatic test_mid_load();
        logic [19:0] e;
        for (int i = 0; i < 32; i++) begin
            adv();
            e = exp_vec(ph, DROP, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mid_load_old ph=%0d got=%h exp=%h", ph, obs(), e);
            end
            if (ph == 16) load_set(COLD, 1'b0);
        end
        for (int i = 0; i < 32; i++) begin
            adv();
            e = exp_vec(ph, COLD, 1'b0, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL mid_load_new ph=%0d got=%h exp=%h", ph, obs(), e);
            end
        end
    endtask

    task automatic test_two_loads();
        logic [19:0] e;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 32; i++) begin
                adv();
                e = exp_vec(ph, COLD, 1'b0, 1'b0);
                checks++;
                if (obs() !== e) begin
                    errors++;
                    $display("FAIL two_loads f=%0d ph=%0d got=%h exp=%h", f, ph, obs(), e);
                end
                if (f == 0 && ph == 5)  load_set(HOT, 1'b1);
                if (f == 0 && ph == 20) load_set(COLD, 1'b0);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [19:0] e;
        load_set(DROP, 1'b1);
        for (int i = 0; i < 64; i++) begin
            adv();
            e = exp_vec(ph, DROP, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL boundary_load i=%0d ph=%0d got=%h exp=%h", i, ph, obs(), e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [19:0] e, z;
        z = exp_vec(0, DROP, 1'b0, 1'b1);
        for (int i = 0; i < 32 && ph != 20; i++) adv();
        e = exp_vec(ph, DROP, 1'b1, 1'b0);
        checks++;
        if (obs() !== e) begin
            errors++;
            $display("FAIL pre_reset ph=%0d got=%h exp=%h", ph, obs(), e);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== z) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs(), z);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (obs() !== z) begin
                errors++;
                $display("FAIL post_reset_idle cyc=%0d got=%h exp=%h", i, obs(), z);
            end
        end
        load_set(DROP, 1'b1);
        @(negedge clk);
        load = 1'b0;
        ph = 0;
        for (int i = 0; i < 12; i++) begin
            e = exp_vec(ph, DROP, 1'b1, 1'b0);
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reload ph=%0d got=%h exp=%h", ph, obs(), e);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_drop();
        test_mid_load();
        test_two_loads();
        test_boundary_load();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
